// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the load/store unit.
// Holds the interface widths, RISC-V funct3 encodings, the FSM state type
// and small decode helpers used by the top level and the load aligner.
package lsu_pkg;

  localparam int unsigned DM_ADDRESS = 9;           // word-address width of data memory
  localparam int unsigned DATA_W     = 32;          // data width
  localparam int unsigned ADDR_W     = 32;          // byte-address width of requests
  localparam int unsigned NB         = DATA_W / 8;  // byte lanes per word
  localparam int unsigned LM_W       = 2 * NB;      // lane mask spanning two words

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} lsu_state_t;

  // Access size in bytes (1, 2 or 4) from funct3.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Lane mask across two consecutive words: bits [NB-1:0] first word, [LM_W-1:NB] second.
  function automatic logic [LM_W-1:0] lane_mask(input logic [1:0] off, input logic [2:0] n);
    logic [LM_W-1:0] m;
    m = LM_W'((LM_W'(1) << n) - LM_W'(1));
    return m << off;
  endfunction

  // True when the access crosses a word boundary.
  function automatic logic is_split(input logic [1:0] off, input logic [2:0] n);
    return ({1'b0, off} + n) > 3'd4;
  endfunction

  // Legal funct3 encodings for loads and stores.
  function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: extracts the addressed bytes from a {hi, lo} word pair
// and sign- or zero-extends them according to funct3.
// Ports: hi_word/lo_word - second/first memory word (hi is 0 when not split)
//        off             - byte offset of the access in lo_word
//        funct3          - RISC-V load funct3
//        load_data_c     - extended 32-bit load value (combinational)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] hi_word,
  input  logic [DATA_W-1:0] lo_word,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] load_data_c
);

  logic [DATA_W-1:0] shifted;

  // Shift the addressed byte down to lane 0, then extend by size/sign.
  always_comb begin
    shifted = DATA_W'({hi_word, lo_word} >> {off, 3'b000});
    case (funct3)
      F3_B:    load_data_c = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_c = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_c = shifted;
      F3_BU:   load_data_c = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data_c = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-organised data memory.
// Accepts byte-addressed RISC-V loads/stores over a valid/ready request,
// issues one or two word accesses (misaligned accesses are split) and
// returns extended load data with a one-cycle rsp_valid pulse.
// Ports: clk, rst (sync, active high); req_* request handshake and payload;
//        rsp_* completion pulse, load data, error; mem_* memory strobe side.
// Build option: define MISALIGN_TRAP_EN to reject word-crossing accesses
// with rsp_err instead of splitting them.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [NB-1:0]         mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned BA_W = DM_ADDRESS + 2;  // byte-address bits actually used
  localparam int unsigned DW2  = 2 * DATA_W;

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] lo_buf_q, lo_buf_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              acc_bad;
  logic [2:0]        size;
  logic [1:0]        off;
  logic              split;
  logic [LM_W-1:0]   be_mask;
  logic [DATA_W-1:0] dmask;
  logic [DW2-1:0]    wshift;
  logic [DATA_W-1:0] load_data;
  logic              unused_addr;

  assign unused_addr = ^req_addr[ADDR_W-1:BA_W];

  // Request rejection decided at accept time.
`ifdef MISALIGN_TRAP_EN
  assign acc_bad = !f3_legal(req_write, req_funct3) ||
                   is_split(req_addr[1:0], size_bytes(req_funct3));
`else
  assign acc_bad = !f3_legal(req_write, req_funct3);
`endif

  // Decode of the latched request: size, lanes and lane-shifted store data.
  always_comb begin
    size    = size_bytes(funct3_q);
    off     = addr_q[1:0];
    split   = is_split(off, size);
    be_mask = lane_mask(off, size);
    case (size)
      3'd1:    dmask = DATA_W'(32'h0000_00FF);
      3'd2:    dmask = DATA_W'(32'h0000_FFFF);
      default: dmask = '1;
    endcase
    wshift = DW2'(wdata_q & dmask) << {off, 3'b000};
  end

  // When split, mem_rdata in FIN holds the second word and lo_buf the first.
  lsu_load_align u_align (
    .hi_word     (split ? mem_rdata : '0),
    .lo_word     (split ? lo_buf_q : mem_rdata),
    .off         (off),
    .funct3      (funct3_q),
    .load_data_c (load_data)
  );

  // Memory strobes decoded from state; reset suppresses any in-flight access.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = addr_q[BA_W-1:2];
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      LO: begin
        mem_en    = 1'b1;
        mem_be    = be_mask[NB-1:0];
        mem_wdata = wshift[DATA_W-1:0];
      end
      HI: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q[BA_W-1:2] + DM_ADDRESS'(1);
        mem_be    = be_mask[LM_W-1:NB];
        mem_wdata = wshift[DW2-1:DATA_W];
      end
      default: ;
    endcase
    if (rst) mem_en = 1'b0;
    mem_we = mem_en & write_q;
  end

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    lo_buf_d    = lo_buf_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr[BA_W-1:0];
          wdata_d  = req_wdata;
          err_d    = acc_bad;
          state_d  = acc_bad ? FIN : LO;
        end
      end
      LO: state_d = split ? HI : FIN;
      HI: begin
        if (!write_q) lo_buf_d = mem_rdata;
        state_d = FIN;
      end
      FIN: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (err_q || write_q) ? '0 : load_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      lo_buf_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      lo_buf_q    <= lo_buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a word-memory model that
// logs every access for checking.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: one-cycle read latency, byte-enabled writes, access log.
  logic [31:0] mem [0:511];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;
  int          log_n = 0;
  logic [8:0]  log_addr  [0:63];
  logic [3:0]  log_be    [0:63];
  logic [31:0] log_wdata [0:63];
  logic        log_we    [0:63];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr];
      log_addr[log_n % 64]  <= mem_addr;
      log_be[log_n % 64]    <= mem_be;
      log_wdata[log_n % 64] <= mem_wdata;
      log_we[log_n % 64]    <= mem_we;
      log_n <= log_n + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request; lat counts cycles from the accept edge (1 = first cycle after).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output int base);
    @(negedge clk);
    base = log_n;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    lat = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                     input logic exp_err, input logic [31:0] exp_rd, input int exp_nacc,
                     output int base);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(w, f3, a, d, rd, er, lat, base);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    check({tag, "_nacc"}, 64'(log_n - base), 64'(exp_nacc));
  endtask

  task automatic acc(input string tag, input int base, input int idx, input logic [8:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic we);
    int i;
    i = (base + idx) % 64;
    check({tag, "_addr"}, 64'(log_addr[i]), 64'(a));
    check({tag, "_be"}, 64'(log_be[i]), 64'(be));
    check({tag, "_we"}, 64'(log_we[i]), 64'(we));
    if (we) check({tag, "_wdata"}, 64'(log_wdata[i]), 64'(wd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_valid", 64'(rsp_valid), 64'(0));
    check("rst_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_mem_en", 64'(mem_en), 64'(0));
    @(negedge clk) rst = 1'b0;

    // Reset in the middle of a split store must not complete the second write.
    preload(9'd4, 32'h5555_AAAA);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h0E; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    check("t1_mem_en_rst0", 64'(mem_en), 64'(0));
    @(negedge clk); #1;
    check("t1_mem_en_rst1", 64'(mem_en), 64'(0));
    @(negedge clk); rst = 1'b0; #1;
    check("t1_ready", 64'(req_ready), 64'(1));
    check("t1_valid", 64'(rsp_valid), 64'(0));
    check("t1_rdata", 64'(rsp_rdata), 64'(0));
    check("t1_word4", 64'(mem[4]), 64'(32'h5555_AAAA));

    // Aligned word store and load.
    txn("sw", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, 1, b);
    acc("sw_a", b, 0, 9'd4, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    txn("lw", 1'b0, F3_W, 32'h10, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1, b);
    acc("lw_a", b, 0, 9'd4, 4'b1111, 32'h0, 1'b0);

    // Sub-word loads with sign/zero extension.
    preload(9'd4, 32'h80FF_0000);
    txn("lb", 1'b0, F3_B, 32'h13, 32'h0, 3, 1'b0, 32'hFFFF_FF80, 1, b);
    acc("lb_a", b, 0, 9'd4, 4'b1000, 32'h0, 1'b0);
    txn("lbu", 1'b0, F3_BU, 32'h13, 32'h0, 3, 1'b0, 32'h0000_0080, 1, b);
    txn("lh", 1'b0, F3_H, 32'h12, 32'h0, 3, 1'b0, 32'hFFFF_80FF, 1, b);
    acc("lh_a", b, 0, 9'd4, 4'b1100, 32'h0, 1'b0);

    // Byte store: upper store-data bits must not leak into other lanes.
    txn("sb", 1'b1, F3_B, 32'h11, 32'hFFFF_FF5A, 3, 1'b0, 32'h0, 1, b);
    acc("sb_a", b, 0, 9'd4, 4'b0010, 32'h0000_5A00, 1'b1);
    txn("lbu2", 1'b0, F3_BU, 32'h11, 32'h0, 3, 1'b0, 32'h0000_005A, 1, b);
    txn("lhu", 1'b0, F3_HU, 32'h12, 32'h0, 3, 1'b0, 32'h0000_80FF, 1, b);

`ifdef MISALIGN_TRAP_EN
    txn("sw_split", 1'b1, F3_W, 32'h0E, 32'h1122_3344, 2, 1'b1, 32'h0, 0, b);
    txn("lw_split", 1'b0, F3_W, 32'h0E, 32'h0, 2, 1'b1, 32'h0, 0, b);
    preload(9'd511, 32'hAB00_0000);
    preload(9'd0, 32'h0000_00CD);
    txn("lh_wrap", 1'b0, F3_H, 32'h7FF, 32'h0, 2, 1'b1, 32'h0, 0, b);
`else
    // Word-crossing store/load split into two accesses.
    txn("sw_split", 1'b1, F3_W, 32'h0E, 32'h1122_3344, 4, 1'b0, 32'h0, 2, b);
    acc("sw_lo", b, 0, 9'd3, 4'b1100, 32'h3344_0000, 1'b1);
    acc("sw_hi", b, 1, 9'd4, 4'b0011, 32'h0000_1122, 1'b1);
    txn("lw_split", 1'b0, F3_W, 32'h0E, 32'h0, 4, 1'b0, 32'h1122_3344, 2, b);
    acc("lw_lo", b, 0, 9'd3, 4'b1100, 32'h0, 1'b0);
    acc("lw_hi", b, 1, 9'd4, 4'b0011, 32'h0, 1'b0);
    // Split halfword wrapping from the last word to word 0.
    preload(9'd511, 32'hAB00_0000);
    preload(9'd0, 32'h0000_00CD);
    txn("lh_wrap", 1'b0, F3_H, 32'h7FF, 32'h0, 4, 1'b0, 32'hFFFF_CDAB, 2, b);
    acc("lh_wrap_lo", b, 0, 9'd511, 4'b1000, 32'h0, 1'b0);
    acc("lh_wrap_hi", b, 1, 9'd0, 4'b0001, 32'h0, 1'b0);
`endif

    // Illegal funct3: no memory access, error response clears load data.
    txn("lbu3", 1'b0, F3_BU, 32'h13, 32'h0, 3, 1'b0, 32'h0000_0080, 1, b);
    txn("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 2, 1'b1, 32'h0, 0, b);
    txn("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h1234_5678, 2, 1'b1, 32'h0, 0, b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
